// File: rtl/stream_array_mp.sv
// Stream-accessed memory: one joined write channel with ack, NR read channels with 1-cycle latency.
// Hardware clear sweep fills every entry with INIT; all readies drop while the sweep runs.
module stream_array_mp #(
  parameter int INT_N  = 32,
  parameter int ADDR_N = 11,
  parameter int NR     = 2,
  parameter logic [INT_N-1:0] INIT = INT_N'(64'h8000_0000)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  output logic                   busy,
  input  logic [ADDR_N-1:0]      wa,
  input  logic                   wa_valid,
  output logic                   wa_ready,
  input  logic [INT_N-1:0]       wd,
  input  logic                   wd_valid,
  output logic                   wd_ready,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  input  logic [NR*ADDR_N-1:0]   ra,
  input  logic [NR-1:0]          ra_valid,
  output logic [NR-1:0]          ra_ready,
  output logic [NR*INT_N-1:0]    rd,
  output logic [NR-1:0]          rd_valid,
  input  logic [NR-1:0]          rd_ready
);
  localparam int N = 2 ** ADDR_N;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_N-1:0] cnt;
  logic              run;
  logic              wfire;
  logic [INT_N-1:0]  mem [N];

  assign run      = (state == S_RUN);
  assign busy     = !run;
  assign wa_ready = run && (!wb_valid || wb_ready);
  assign wd_ready = wa_ready;
  assign wfire    = wa_valid && wd_valid && wa_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + ADDR_N'(1);
          if (cnt == {ADDR_N{1'b1}}) state <= S_RUN;
        end
        default: begin
          if (clear) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // The sweep owns the single write port; writes can only fire in RUN.
  always_ff @(posedge clk) begin
    if (!run) mem[cnt] <= INIT;
    else if (wfire) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) wb_valid <= 1'b0;
    else if (wfire) wb_valid <= 1'b1;
    else if (wb_ready) wb_valid <= 1'b0;
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [ADDR_N-1:0] addr;
    logic              fire;
    logic              vld_q;
    logic [INT_N-1:0]  dat_q;

    assign addr        = ra[k*ADDR_N +: ADDR_N];
    assign ra_ready[k] = run && (!vld_q || rd_ready[k]);
    assign fire        = ra_valid[k] && ra_ready[k];

    // Write-first: a same-cycle write to the read address is forwarded.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else if (fire) begin
        vld_q <= 1'b1;
        dat_q <= (wfire && wa == addr) ? wd : mem[addr];
      end else if (rd_ready[k]) begin
        vld_q <= 1'b0;
      end
    end

    assign rd_valid[k]           = vld_q;
    assign rd[k*INT_N +: INT_N]  = dat_q;
  end
endmodule
